// File: rtl/note_sequencer_pkg.sv
// Shared note table, divisor helper and FSM state type for the note sequencer.
package note_pkg;
  localparam int NUM_NOTES = 8;
  localparam int IDX_W     = 3;
  localparam int NOTE_HZ [NUM_NOTES] = '{262, 294, 330, 349, 392, 440, 494, 523};

  typedef enum logic [1:0] {IDLE, MANUAL, AUTO_PLAY, AUTO_GAP} seq_state_t;

  function automatic logic [31:0] note_div(input int unsigned clk_hz, input int idx);
    return 32'(clk_hz / 32'(NOTE_HZ[idx]));
  endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// User-control / NDivider-facing signal bundle of the note sequencer.
interface note_sequencer_if;
  import note_pkg::*;
  logic             start_btn;
  logic             stop_btn;
  logic             auto_mode;
  logic [IDX_W-1:0] note_sel;
  logic [31:0]      divisor;
  logic             audio_en;
  logic [IDX_W-1:0] note_idx;
  logic             step_pulse;
  logic             busy;

  modport master (output start_btn, stop_btn, auto_mode, note_sel,
                  input  divisor, audio_en, note_idx, step_pulse, busy);
  modport slave  (input  start_btn, stop_btn, auto_mode, note_sel,
                  output divisor, audio_en, note_idx, step_pulse, busy);
endinterface

// File: rtl/note_sequencer_sync_edge.sv
// 2-FF synchroniser for an async pushbutton plus a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic s1, s2, s2_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s2_d <= s2;
    end

  assign rise = s2 & ~s2_d;
endmodule

// File: rtl/note_sequencer.sv
// Turns start/stop buttons, mode and note switches into an NDivider divisor
// plus audio gate; auto mode walks the C4..C5 scale with a silent gap per note.
module note_sequencer
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned NOTE_TICKS = 25_000_000,
  parameter int unsigned GAP_TICKS  = 2_500_000,
  parameter bit          LOOP       = 1'b1
) (
  input logic             inclk,
  input logic             reset,
  note_sequencer_if.slave bus
);
  localparam logic [31:0] PLAY_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

  logic [31:0] div_rom [NUM_NOTES];
  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_rom
    assign div_rom[i] = note_div(CLK_HZ, i);
  end

  logic start_e, stop_e;
  sync_edge u_start (.clk(inclk), .rst_n(reset), .d(bus.start_btn), .rise(start_e));
  sync_edge u_stop  (.clk(inclk), .rst_n(reset), .d(bus.stop_btn),  .rise(stop_e));

  // Switches are levels: synchronise {auto_mode, note_sel} without edge detection.
  logic [IDX_W:0] sw_s1, sw_s2;
  always_ff @(posedge inclk or negedge reset)
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= {bus.auto_mode, bus.note_sel};
      sw_s2 <= sw_s1;
    end

  logic             auto_s;
  logic [IDX_W-1:0] sel_s;
  assign auto_s = sw_s2[IDX_W];
  assign sel_s  = sw_s2[IDX_W-1:0];

  seq_state_t       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [31:0]      cnt, cnt_n;
  logic             step, step_n;
  logic [31:0]      div_q;

  always_ff @(posedge inclk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      step  <= 1'b0;
      div_q <= note_div(CLK_HZ, 0);
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      step  <= step_n;
      div_q <= div_rom[idx];
    end

  // Stop outranks start; a start edge always re-samples auto_mode.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    step_n  = 1'b0;
    if (stop_e) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (start_e) begin
      cnt_n = '0;
      if (auto_s) begin
        state_n = AUTO_PLAY;
        idx_n   = '0;
      end else begin
        state_n = MANUAL;
        idx_n   = sel_s;
      end
    end else begin
      unique case (state)
        MANUAL: idx_n = sel_s;
        AUTO_PLAY:
          if (cnt == PLAY_LAST) begin
            state_n = AUTO_GAP;
            cnt_n   = '0;
          end else cnt_n = cnt + 32'd1;
        AUTO_GAP:
          if (cnt == GAP_LAST) begin
            cnt_n = '0;
            if (!LOOP && idx == IDX_W'(NUM_NOTES - 1)) state_n = IDLE;
            else begin
              state_n = AUTO_PLAY;
              idx_n   = idx + IDX_W'(1);
              step_n  = 1'b1;
            end
          end else cnt_n = cnt + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.divisor    = div_q;
  assign bus.audio_en   = (state == MANUAL) || (state == AUTO_PLAY);
  assign bus.note_idx   = idx;
  assign bus.step_pulse = step;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboarded bench: a looping and a one-shot sequencer share the same controls.
module tb_note_sequencer;
  import note_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic       start, stop, automode;
  logic [2:0] sel;

  note_sequencer_if bi0 ();
  note_sequencer_if bi1 ();
  assign bi0.start_btn = start;
  assign bi0.stop_btn  = stop;
  assign bi0.auto_mode = automode;
  assign bi0.note_sel  = sel;
  assign bi1.start_btn = start;
  assign bi1.stop_btn  = stop;
  assign bi1.auto_mode = automode;
  assign bi1.note_sel  = sel;

  note_sequencer #(.CLK_HZ(1000), .NOTE_TICKS(8), .GAP_TICKS(2), .LOOP(1'b1))
    u_loop (.inclk(clk), .reset(rst_n), .bus(bi0));
  note_sequencer #(.CLK_HZ(1000), .NOTE_TICKS(8), .GAP_TICKS(2), .LOOP(1'b0))
    u_once (.inclk(clk), .reset(rst_n), .bus(bi1));

  int checks = 0;
  int errors = 0;
  int nstep0 = 0;
  int nstep1 = 0;
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: step_pulse got 1 expected 0 (no entry queued)", name);
  endtask

  // Scoreboard monitor: every step_pulse must match the next queued note index.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bi0.step_pulse) begin
        nstep0++;
        if (q0.size() == 0) unexpected("loop_step");
        else chk("loop_step_idx", 32'(bi0.note_idx), 32'(q0.pop_front()));
      end
      if (bi1.step_pulse) begin
        nstep1++;
        if (q1.size() == 0) unexpected("once_step");
        else chk("once_step_idx", 32'(bi1.note_idx), 32'(q1.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic p);
    start = s;
    stop  = p;
    tick(2);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int n;
    start = 1'b0; stop = 1'b0; automode = 1'b0; sel = 3'd0;

    // Reset state: divisor = 1000/262 = 3
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_div",  bi0.divisor, 32'd3);
    chk("rst_aud",  32'(bi0.audio_en), 32'd0);
    chk("rst_idx",  32'(bi0.note_idx), 32'd0);
    chk("rst_busy", 32'(bi0.busy), 32'd0);
    chk("rst_step", 32'(bi0.step_pulse), 32'd0);

    // Manual mode: 5 -> 1000/440 = 2, 2 -> 1000/330 = 3, 7 -> 1000/523 = 1
    sel = 3'd5;
    press(1'b1, 1'b0);
    tick(2);
    chk("man_busy", 32'(bi0.busy), 32'd1);
    chk("man_aud",  32'(bi0.audio_en), 32'd1);
    chk("man_idx5", 32'(bi0.note_idx), 32'd5);
    chk("man_div5", bi0.divisor, 32'd2);
    sel = 3'd2;
    tick(5);
    chk("man_idx2", 32'(bi0.note_idx), 32'd2);
    chk("man_div2", bi0.divisor, 32'd3);
    sel = 3'd7;
    tick(5);
    chk("man_div7", bi0.divisor, 32'd1);
    press(1'b0, 1'b1);
    tick(2);
    chk("man_stop_busy", 32'(bi0.busy), 32'd0);
    chk("man_stop_aud",  32'(bi0.audio_en), 32'd0);
    chk("man_stop_idx",  32'(bi0.note_idx), 32'd7);

    // Auto mode: 8 cycles sounding, 2 silent, step; loop wraps, one-shot stops after 7
    automode = 1'b1;
    sel = 3'd6;
    for (int k = 1; k <= 7; k++) begin
      q0.push_back(3'(k));
      q1.push_back(3'(k));
    end
    q0.push_back(3'd0);
    press(1'b1, 1'b0);
    n = 0;
    while (!bi0.busy && n < 10) begin tick(1); n++; end
    chk("auto_busy", 32'(bi0.busy), 32'd1);
    chk("auto_idx0", 32'(bi0.note_idx), 32'd0);
    for (int j = 1; j <= 9; j++) begin
      tick(1);
      chk("auto_aud_pattern", 32'(bi0.audio_en), 32'(j < 8));
    end
    tick(1);
    chk("auto_step1", 32'(bi0.step_pulse), 32'd1);
    chk("auto_idx1",  32'(bi0.note_idx), 32'd1);
    n = 0;
    while (nstep0 < 8 && n < 120) begin tick(1); n++; end
    chk("loop_steps",   32'(nstep0), 32'd8);
    chk("loop_wrap",    32'(bi0.note_idx), 32'd0);
    chk("loop_busy",    32'(bi0.busy), 32'd1);
    chk("once_steps",   32'(nstep1), 32'd7);
    chk("once_busy",    32'(bi1.busy), 32'd0);
    chk("once_aud",     32'(bi1.audio_en), 32'd0);
    chk("once_idx",     32'(bi1.note_idx), 32'd7);
    press(1'b0, 1'b1);
    tick(2);
    chk("auto_stop_busy", 32'(bi0.busy), 32'd0);

    // Start and stop edges together during AUTO_PLAY: stop wins, note held
    q0.push_back(3'd1); q0.push_back(3'd2);
    q1.push_back(3'd1); q1.push_back(3'd2);
    press(1'b1, 1'b0);
    n = 0;
    while (bi0.note_idx != 3'd2 && n < 60) begin tick(1); n++; end
    chk("both_reach2", 32'(bi0.note_idx), 32'd2);
    press(1'b1, 1'b1);
    tick(2);
    chk("both_busy",  32'(bi0.busy), 32'd0);
    chk("both_aud",   32'(bi0.audio_en), 32'd0);
    chk("both_idx",   32'(bi0.note_idx), 32'd2);
    chk("both_idx_1", 32'(bi1.note_idx), 32'd2);

    // Reset mid-note: outputs clear before any clock edge
    q0.push_back(3'd1);
    q1.push_back(3'd1);
    press(1'b1, 1'b0);
    n = 0;
    while (bi0.note_idx != 3'd1 && n < 40) begin tick(1); n++; end
    chk("mid_reach1", 32'(bi0.note_idx), 32'd1);
    tick(3);
    chk("mid_div1", bi0.divisor, 32'd3);
    chk("mid_aud",  32'(bi0.audio_en), 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_div",  bi0.divisor, 32'd3);
    chk("arst_aud",  32'(bi0.audio_en), 32'd0);
    chk("arst_idx",  32'(bi0.note_idx), 32'd0);
    chk("arst_busy", 32'(bi0.busy), 32'd0);
    chk("arst_step", 32'(bi0.step_pulse), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    chk("sb_drain_loop", 32'(q0.size()), 32'd0);
    chk("sb_drain_once", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
